// File: rtl/omsp_hash_frontend_p.sv
// Host-side frontend for the Sancus hash cores: packs 8/16-bit host writes into
// CORE_W-bit core words, sequences core commands on a clock enable and serialises the hash.
module omsp_hash_frontend_p #(
   parameter int CORE_W = 32,
   parameter int CE_DIV = 2,
   parameter int CNT_W  = $clog2(CORE_W/8+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cmd_in,
   input  logic [15:0]       data_in,
   input  logic              data_size,
   output logic [15:0]       hash_out,
   output logic              busy,
   output logic              ready_for_data,
   output logic              err,
   output logic              core_ce,
   output logic [1:0]        core_cmd,
   output logic [CORE_W-1:0] core_data,
   output logic [CNT_W-1:0]  core_bytes,
   output logic              core_data_valid,
   input  logic              core_data_ack,
   input  logic              core_busy,
   input  logic [CORE_W-1:0] core_hash,
   input  logic              core_hash_valid,
   output logic              core_hash_ack
);

   localparam int NB = CORE_W / 8;
   localparam int NS = CORE_W / 16;
   localparam int SI_W = $clog2(NS);
   localparam logic [CNT_W-1:0] NB_C = CNT_W'(NB);
   localparam logic [CNT_W:0]   NB_X = (CNT_W+1)'(NB);
   localparam logic [SI_W-1:0]  SI_LAST = SI_W'(NS-1);

   logic [3:0]        ce_cnt;
   logic [CORE_W-1:0] packer, pk_n, xfer_data;
   logic [CNT_W-1:0]  pc, pc_n, xfer_bytes, wr_n;
   logic [CNT_W:0]    wr_sum;
   logic              xfer, hold_free, fits, wr_cycle, rd_cycle, wr_ok, prev_wr;
   logic [7:0]        b_first;
   logic [1:0]        cmd_eff, cmd_next;
   logic [CORE_W-1:0] rb_buf;
   logic [SI_W-1:0]   si;
   logic              rb_full, hash_load;

   // Places one byte into lane pos of the word, lane 0 being the most significant byte.
   function automatic logic [CORE_W-1:0] put_byte(input logic [CORE_W-1:0] w,
                                                  input logic [CNT_W-1:0] pos,
                                                  input logic [7:0] b);
      logic [CORE_W-1:0] r;
      r = w;
      for (int k = 0; k < NB; k++)
         if (pos == CNT_W'(k)) r[CORE_W-1-8*k -: 8] = b;
      return r;
   endfunction

   assign core_ce = (ce_cnt == 4'(CE_DIV-1));

   always_ff @(posedge clk or posedge rst)
      if (rst)          ce_cnt <= '0;
      else if (core_ce) ce_cnt <= '0;
      else              ce_cnt <= ce_cnt + 4'd1;

   assign wr_cycle       = (cmd_in == 2'b10);
   assign rd_cycle       = (cmd_in == 2'b01);
   assign cmd_eff        = (cmd_in == 2'b11) ? 2'b00 : cmd_in;
   assign hold_free      = !core_data_valid || (core_ce && core_data_ack);
   assign wr_n           = data_size ? CNT_W'(2) : CNT_W'(1);
   assign wr_sum         = {1'b0, pc} + {1'b0, wr_n};
   assign fits           = (wr_sum <= NB_X);
   assign ready_for_data = hold_free || fits;
   assign wr_ok          = wr_cycle && ready_for_data;
   assign busy           = core_busy || core_data_valid || (pc != '0) || (cmd_next != core_cmd);

   // A full packer drains first so a new write starts a fresh word; a word write
   // at the last lane completes the current word and spills its low byte into the next.
   always_comb begin
      pk_n       = packer;
      pc_n       = pc;
      xfer       = 1'b0;
      xfer_data  = '0;
      xfer_bytes = '0;
      b_first    = data_size ? data_in[15:8] : data_in[7:0];
      if (pc == NB_C && hold_free) begin
         xfer = 1'b1; xfer_data = packer; xfer_bytes = NB_C; pk_n = '0; pc_n = '0;
      end
      if (wr_ok) begin
         pk_n = put_byte(pk_n, pc_n, b_first);
         pc_n = pc_n + CNT_W'(1);
         if (data_size) begin
            if (pc_n == NB_C && !xfer) begin
               xfer = 1'b1; xfer_data = pk_n; xfer_bytes = NB_C; pk_n = '0; pc_n = '0;
            end
            pk_n = put_byte(pk_n, pc_n, data_in[7:0]);
            pc_n = pc_n + CNT_W'(1);
         end
      end
      if (!xfer && hold_free && (pc_n == NB_C || (!wr_cycle && pc_n != '0))) begin
         xfer = 1'b1; xfer_data = pk_n; xfer_bytes = pc_n; pk_n = '0; pc_n = '0;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         packer          <= '0;
         pc              <= '0;
         core_data       <= '0;
         core_bytes      <= '0;
         core_data_valid <= 1'b0;
      end else begin
         packer <= pk_n;
         pc     <= pc_n;
         if (xfer) begin
            core_data       <= xfer_data;
            core_bytes      <= xfer_bytes;
            core_data_valid <= 1'b1;
         end else if (core_ce && core_data_ack) begin
            core_data_valid <= 1'b0;
         end
      end

   // Overflow is sticky until the host starts a fresh write run.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         err     <= 1'b0;
         prev_wr <= 1'b0;
      end else begin
         prev_wr <= wr_cycle;
         if (wr_cycle && !ready_for_data) err <= 1'b0 | 1'b1;
         else if (wr_cycle && !prev_wr)  err <= 1'b0;
      end

   // The core keeps seeing write while a partial word still sits in the packer.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cmd_next <= 2'b00;
         core_cmd <= 2'b00;
      end else begin
         if (cmd_eff != core_cmd && (ready_for_data || !busy)) cmd_next <= cmd_eff;
         if (core_ce && !(pc != '0 && core_cmd == 2'b10)) core_cmd <= cmd_next;
      end

   assign hash_load     = !rb_full && core_hash_valid && core_ce;
   assign core_hash_ack = hash_load;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rb_buf  <= '0;
         rb_full <= 1'b0;
         si      <= '0;
      end else if (hash_load) begin
         rb_buf  <= core_hash;
         rb_full <= 1'b1;
         si      <= '0;
      end else if (rd_cycle && rb_full) begin
         if (si == SI_LAST) begin
            rb_full <= 1'b0;
            si      <= '0;
         end else begin
            si <= si + SI_W'(1);
         end
      end

   always_comb begin
      hash_out = '0;
      if (rb_full)
         for (int k = 0; k < NS; k++)
            if (si == SI_W'(k)) hash_out = rb_buf[CORE_W-1-16*k -: 16];
   end

endmodule

// File: doc/omsp_hash_frontend_p.md
# omsp_hash_frontend_p

Parametrised host-side frontend for the Sancus hash cores. It packs 8- and 16-bit host writes into CORE_W-bit core words, including partial-word flush, and sequences commands to the core on a clock-enable instead of a derived clock. It also serialises the core's CORE_W-bit hash output into 16-bit host reads. It sits between the openMSP430 peripheral register interface and any hash core (SHA-512, SHA-256, Spongent) with a valid/ack data port.

## Interface
Parameters:
- CORE_W, 32: core data/hash word width. Must be a multiple of 16, range 32..128.
- CE_DIV, 2: core clock-enable period in clk cycles, 1..8.
- CNT_W, $clog2(CORE_W/8+1): width of the byte-count fields.

Ports:
- clk  in  1  system clock; the core is clocked by clk and qualified by core_ce.
- rst  in  1  reset, asynchronous, active-high.
- cmd_in  in  2  host command: bit1 = write, bit0 = read; 00 = idle; 11 is treated as idle.
- data_in  in  16  host write data.
- data_size  in  1  1 = 16-bit write; 0 = byte write, carried in data_in[7:0].
- hash_out  out  16  current 16-bit hash slice, MSB slice first.
- busy  out  1  a command or data is pending, or core_busy is high.
- ready_for_data  out  1  a write in this cycle will be accepted.
- err  out  1  sticky flag for a write dropped on overflow; cleared by rst or by a write after idle.
- core_ce  out  1  core clock enable.
- core_cmd  out  2  registered command to the core.
- core_data  out  CORE_W  packed data word, MSB-first, zero-padded in the low bytes.
- core_bytes  out  CNT_W  valid bytes in core_data, range 1..CORE_W/8.
- core_data_valid  out  1  core_data is held and valid.
- core_data_ack  in  1  core consumes core_data; sampled only when core_ce is high.
- core_busy  in  1  core busy.
- core_hash  in  CORE_W  core hash word.
- core_hash_valid  in  1  core_hash is valid.
- core_hash_ack  out  1  one-clk pulse aligned with core_ce; the hash word has been captured.

## Operation
- CE counter: counts 0..CE_DIV-1 and wraps. core_ce = (count == CE_DIV-1). When CE_DIV = 1, core_ce is held at 1.
- Write cycle: cmd_in[1] high and cmd_in[0] low. Each write cycle with ready_for_data high appends data to the packer:
  - byte write: 1 byte.
  - word write: 2 bytes, data_in[15:8] first.
  - Bytes are placed MSB-first.
- Packer: CORE_W-bit shift register with a byte count pc.
  - When pc reaches CORE_W/8 and the holding register is empty, transfer the word: core_data ← packer, core_bytes ← CORE_W/8, core_data_valid ← 1, pc ← 0.
  - A word write at pc = CORE_W/8-1 straddles two words: the high byte completes the current word and the low byte becomes byte 0 of the next word (pc = 1).
- Holding register: core_data_valid clears on the clk edge where core_ce && core_data_ack. The packer may transfer in that same cycle.
- ready_for_data = !(holding full && packer cannot absorb the write). Capacity is 1 byte for a byte write and 2 bytes for a word write.
- Overflow: a write while ready_for_data is low is dropped and sets err.
- Flush: on the first non-write cycle after a write run, with pc > 0, move the partial word to the holding register: zero-padded low bytes, core_bytes = pc.
  - If the holding register is full, the flush waits; busy stays high.
- Command path:
  - cmd_next captures cmd_in when it differs from core_cmd and (ready_for_data || !busy).
  - core_cmd ← cmd_next only on core_ce. While a flush is pending, core_cmd must not leave write.
- Readback buffer: CORE_W bits with slice index si (0..CORE_W/16-1) and a full flag.
  - Load when !full && core_hash_valid && core_ce. The same cycle asserts core_hash_ack, sets full and sets si = 0.
  - hash_out = buffer slice si. It is 0 when the buffer is empty.
  - Each read cycle (cmd_in = 01) with full set increments si. Reading the last slice clears full.
  - A read cycle with the buffer empty leaves state unchanged; hash_out = 0.
- busy = core_busy || core_data_valid || pc ≠ 0 || (cmd_next ≠ core_cmd).

## Timing
- Reset values: CE count = 0, pc = 0, holding register empty, err = 0, core_cmd = 00, cmd_next = 00, buffer empty, si = 0.
- Output reset values: hash_out = 0, busy = 0, core_data_valid = 0, core_data = 0, core_bytes = 0, core_hash_ack = 0, core_ce = (CE_DIV == 1).
- ready_for_data is 1 after reset.
- Write to core_data_valid latency: 1 clk after the write that fills the word, when the holding register is empty.
- Command latency: core_cmd updates at the first core_ce edge at least 1 clk after the cmd_in change, so ≤ CE_DIV+1 clk.
- Simultaneous ack and transfer in one cycle: no bubble and no data loss.
- Simultaneous last-slice read and new core_hash_valid with core_ce: the read completes first and the reload occurs on the next core_ce.
- rst mid-operation: all state clears immediately, including a partially packed word; there is no flush.

## Test plan
- CORE_W=32, CE_DIV=2, word writes 0x1122 then 0x3344 → core_data = 0x11223344, core_bytes = 4, valid held until the ack on core_ce.
- CORE_W=32, bytes 0xAA, then words 0xBBCC, 0xDDEE, then idle → first word 0xAABBCCDD with core_bytes = 4; after flush, second word 0xEE000000 with core_bytes = 1.
- core_data_ack held 0 while writing 8 words → ready_for_data drops after 8 bytes buffered; the next write is dropped and err = 1; no corruption of held data.
- CORE_W=64, core_hash = 0x0123456789ABCDEF → four reads return 0x0123, 0x4567, 0x89AB, 0xCDEF; core_hash_ack pulses once, on a core_ce cycle.
- CE_DIV=3, cmd_in 00→10 → core_cmd = 10 within 4 clk, changing only on a core_ce cycle.
- rst asserted with pc = 3 and the holding register full → all outputs return to reset values the same cycle, and no flush occurs after reset is released.
